// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program counter with return-address stack:
// default geometry and the per-cycle command priority encoding.
package pc_stack_pkg;

  localparam int DEF_AW    = 12;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INC  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_RET  = 3'd3,
    CMD_CALL = 3'd4
  } cmd_e;

  // Priority: call > ret > load > enabled > hold; losers are silently dropped.
  function automatic cmd_e decode_cmd(input logic call, input logic ret,
                                      input logic load, input logic enabled);
    cmd_e c;
    if (call)         c = CMD_CALL;
    else if (ret)     c = CMD_RET;
    else if (load)    c = CMD_LOAD;
    else if (enabled) c = CMD_INC;
    else              c = CMD_HOLD;
    return c;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Command/status bundle between Decode (master) and the program counter (slave).
interface pc_stack_if
  import pc_stack_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SPW   = $clog2(DEPTH + 1)
);
  // No valid/ready handshake: every command input is a level sampled on each
  // rising clock edge, always accepted, and its effect is visible one cycle later.
  logic            enabled;
  logic            load;
  logic            call;
  logic            ret;
  logic            clr_err;
  logic [AW-1:0]   D;
  logic [AW-1:0]   Q;
  logic [SPW-1:0]  sp;
  logic            stack_empty;
  logic            stack_full;
  logic            overflow;
  logic            underflow;

  modport master (
    output enabled, load, call, ret, clr_err, D,
    input  Q, sp, stack_empty, stack_full, overflow, underflow
  );

  modport slave (
    input  enabled, load, call, ret, clr_err, D,
    output Q, sp, stack_empty, stack_full, overflow, underflow
  );
endinterface

// File: rtl/pc_lifo.sv
// DEPTH x AW return-address register file with occupancy counter.
// Push-when-full and pop-when-empty change nothing and raise an error strobe.
module pc_lifo
  import pc_stack_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [AW-1:0]  push_data_i,
  output logic [AW-1:0]  top_o,
  output logic [SPW-1:0] sp_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           push_err_o,
  output logic           pop_err_o
);
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;

  // Push wins over a simultaneous pop, matching the call > ret priority.
  assign push_err_o = push_i & full_o;
  assign pop_err_o  = pop_i & ~push_i & empty_o;

  assign wr_idx = sp_q[IW-1:0];
  assign rd_idx = IW'(sp_q - SPW'(1));
  assign top_o  = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i) begin
      if (!full_o) sp_d = sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      if (push_i && !full_o) mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with reset/load/increment plus CALL/RET through a
// return-address stack, reporting depth and sticky overflow/underflow.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic       clock,
  input  logic       reset,
  pc_stack_if.slave  bus
);
  cmd_e           cmd;
  logic [AW-1:0]  q_q, q_d;
  logic [AW-1:0]  q_inc;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic [AW-1:0]  top;
  logic [SPW-1:0] sp;
  logic           full, empty;
  logic           push_err, pop_err;

  assign cmd   = decode_cmd(bus.call, bus.ret, bus.load, bus.enabled);
  // Natural AW-bit wrap serves both increment and the pushed return address.
  assign q_inc = q_q + AW'(1);

  pc_lifo #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .SPW   (SPW)
  ) u_lifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (cmd == CMD_CALL),
    .pop_i       (cmd == CMD_RET),
    .push_data_i (q_inc),
    .top_o       (top),
    .sp_o        (sp),
    .full_o      (full),
    .empty_o     (empty),
    .push_err_o  (push_err),
    .pop_err_o   (pop_err)
  );

  always_comb begin
    q_d = q_q;
    unique case (cmd)
      CMD_CALL: q_d = bus.D;
      CMD_RET:  q_d = empty ? q_q : top;
      CMD_LOAD: q_d = bus.D;
      CMD_INC:  q_d = q_inc;
      default:  q_d = q_q;
    endcase
  end

  // A new error event outranks clr_err in the same cycle.
  always_comb begin
    overflow_d  = bus.clr_err ? 1'b0 : overflow_q;
    underflow_d = bus.clr_err ? 1'b0 : underflow_q;
    if (push_err) overflow_d  = 1'b1;
    if (pop_err)  underflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.Q           = q_q;
  assign bus.sp          = sp;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised successor to the 12-bit program counter: adds a hardware return-address stack for CALL/RET alongside the existing reset, load and increment.
- Sits between Decode and the program ROM. Q addresses ROM; D comes from the {oprnd, program_byte} jump target.
- Reports stack depth and sticky overflow/underflow flags so the control path or a debug port can detect runaway recursion.

Parameters:
- AW, 12, address width of PC, D and each stack entry
- DEPTH, 4, number of return-address entries (power of two, >=2)
- SPW, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enabled  in  1  increment PC by 1
- load  in  1  jump: Q <= D
- call  in  1  push return address Q+1, then Q <= D
- ret  in  1  Q <= top of stack, pop
- D  in  AW  jump/call target
- clr_err  in  1  synchronous clear of sticky error flags
- Q  out  AW  current program counter
- sp  out  SPW  number of valid stack entries, 0..DEPTH
- stack_empty  out  1  sp == 0
- stack_full  out  1  sp == DEPTH
- overflow  out  1  sticky: call issued while full
- underflow  out  1  sticky: ret issued while empty

Behaviour:
- Reset (reset low, asynchronous): Q=0, sp=0, overflow=0, underflow=0, all stack entries=0. stack_empty=1, stack_full=0.
- All updates happen on the rising clock edge; Q reflects the command one cycle later, with no combinational path from inputs to Q.
- Command priority per cycle: call > ret > load > enabled > hold. Lower-priority inputs asserted in the same cycle are ignored.
- call, not full: entry[sp] <= Q+1 (mod 2^AW); sp <= sp+1; Q <= D.
- call, full: stack and sp unchanged; Q <= D (jump still taken); overflow <= 1.
- ret, not empty: Q <= entry[sp-1]; sp <= sp-1. The popped entry keeps its value but is no longer valid.
- ret, empty: Q holds; sp stays 0; underflow <= 1.
- load: Q <= D; stack untouched.
- enabled: Q <= Q+1; 2^AW-1 wraps to 0. The return address computed by call wraps the same way.
- call and ret in the same cycle: call wins, ret is dropped, no error flagged.
- clr_err: clears overflow and underflow next edge. If an error event occurs in the same cycle, the set wins and the flag stays 1.
- Flags and sp are registered. stack_empty and stack_full decode combinationally from registered sp.
- Reset asserted mid-sequence discards all stack contents immediately. Operation resumes on the first edge after reset deasserts.

Decomposition:
- Shared package: command-priority encoding (CMD_CALL, CMD_RET, CMD_LOAD, CMD_INC, CMD_HOLD) and default AW/DEPTH constants, reused by Decode and the top-level uP.
- One sub-module, pc_lifo: DEPTH x AW register file with sp counter, push/pop, full/empty. Push-when-full and pop-when-empty are no-ops that assert an error strobe.
- pc_stack holds the Q register, the command mux and the sticky flags.

Test Plan (AW=12, DEPTH=4):
- Reset then enabled for 3 cycles -> Q=0x000,0x001,0x002,0x003; sp=0; stack_empty=1.
- Q=0x010, call D=0x200 -> Q=0x200, sp=1, entry0=0x011; then ret -> Q=0x011, sp=0, stack_empty=1.
- Four nested calls from Q=0x100/0x200/0x300/0x400 to D=0x200/0x300/0x400/0x500 -> sp=4, stack_full=1. A fifth call to D=0x600 -> Q=0x600, sp=4, overflow=1. Four rets -> Q=0x401,0x301,0x201,0x101.
- ret with sp=0 at Q=0x055 -> Q=0x055, underflow=1. clr_err -> underflow=0 next cycle. clr_err in the same cycle as a new underflow -> underflow stays 1.
- Q=0xFFF: enabled -> Q=0x000. Separately, Q=0xFFF with call D=0x123 -> pushed entry=0x000, Q=0x123.
- call+ret+load+enabled together with D=0x0AA, Q=0x010 -> call executes: Q=0x0AA, sp+1, no error flag.
- reset pulsed low mid-cycle while sp=3 -> Q=0, sp=0 immediately, without waiting for a clock edge.
